sigmoid_pipe: RTL and testbench

SIGMOID_PIPE -- requirements
Module: sigmoid_pipe

---
 rtl/sigmoid_pkg.sv | 31 +++
 rtl/sigmoid_lane.sv | 115 +++++++++++
 rtl/sigmoid_pipe.sv | 57 +++++
 tb/tb_sigmoid_pipe.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sigmoid_pkg.sv
// sigmoid_pkg: fixed-point constants and per-stage control type for sigmoid_pipe.
// Constants are functions of the fractional width F (1.0 == 2^F); saturation rails sit at +/-4.0.
// The mode field exists only when SIGMOID_TANH_EN is defined.
package sigmoid_pkg;

  // 1.0 in fixed point
  function automatic int sig_one(input int f);
    return 1 << f;
  endfunction

  // +4.0: at or above this the sigmoid is pinned to 1.0
  function automatic int sig_sat_pos(input int f);
    return 4 << f;
  endfunction

  // -4.0: at or below this the sigmoid is pinned to 0
  function automatic int sig_sat_neg(input int f);
    return -(4 << f);
  endfunction

  // Control that travels beside t / product through the stages
  typedef struct packed {
    logic vld;
`ifdef SIGMOID_TANH_EN
    logic mode;
`endif
    logic sat;
    logic sign;
  } sig_ctl_t;

endpackage

// File: rtl/sigmoid_lane.sv
// sigmoid_lane: one channel of the piecewise-quadratic sigmoid (tanh with SIGMOID_TANH_EN).
// Latency: 3 register stages (S1 classify/t, S2 t*t, S3 final add + output register).
// Backpressure: all stages hold while i_en is low; the control owner decides when to advance.
module sigmoid_lane
  import sigmoid_pkg::*;
#(
  parameter int W = 16,
  parameter int F = W / 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  input  logic         i_vld,
`ifdef SIGMOID_TANH_EN
  input  logic         i_mode,
`endif
  input  logic [W-1:0] i_x,
  output logic [W-1:0] o_y,
  output logic         o_sat
);

  localparam logic        [W-1:0]   ONE_W   = W'(sig_one(F));
  localparam logic        [2*W-1:0] ONE_2W  = (2*W)'(sig_one(F));
  localparam logic signed [W-1:0]   SAT_POS = W'(sig_sat_pos(F));
  localparam logic signed [W-1:0]   SAT_NEG = W'(sig_sat_neg(F));

  logic signed [W-1:0] w_xc;
  logic                w_sat;
  logic        [W-1:0] w_abs;
  logic        [W-1:0] w_t;
  logic      [2*W-1:0] w_sig;
  logic      [2*W-1:0] w_y;

  sig_ctl_t            r_c1;
  sig_ctl_t            r_c2;
  logic        [W-1:0] r_t;
  logic      [2*W-1:0] r_prod;

`ifdef SIGMOID_TANH_EN
  localparam logic signed [W:0] SAT_POS_X = (W+1)'(sig_sat_pos(F));
  localparam logic signed [W:0] SAT_NEG_X = (W+1)'(sig_sat_neg(F));
  logic signed [W:0] w_x2;
  assign w_x2 = $signed({i_x, 1'b0});

  // tanh feeds the core with 2x, clamped to the rails so it cannot wrap
  always_comb begin
    w_xc = $signed(i_x);
    if (i_mode) begin
      if (w_x2 > SAT_POS_X)      w_xc = SAT_POS;
      else if (w_x2 < SAT_NEG_X) w_xc = SAT_NEG;
      else                       w_xc = w_x2[W-1:0];
    end
  end
`else
  assign w_xc = $signed(i_x);
`endif

  // Rails are tested on the raw operand, so |x| below is only used when |x| < 4.0
  assign w_sat = (w_xc >= SAT_POS) || (w_xc <= SAT_NEG);
  assign w_abs = w_xc[W-1] ? ($unsigned(~w_xc) + 1'b1) : $unsigned(w_xc);
  assign w_t   = ONE_W - (w_abs >> 2);

  // Final add: rail value or 1/2*t^2 reflected by sign; tanh rescales as 2*sig - 1
  always_comb begin
    if (r_c2.sat)       w_sig = r_c2.sign ? '0 : ONE_2W;
    else if (r_c2.sign) w_sig = r_prod >> (F + 1);
    else                w_sig = ONE_2W - (r_prod >> (F + 1));
    w_y = w_sig;
`ifdef SIGMOID_TANH_EN
    if (r_c2.mode) w_y = (w_sig << 1) - ONE_2W;
`endif
  end

  // S1 control: valid, rail hit and sign of the core operand
  always_ff @(posedge clk) begin
    if (rst) begin
      r_c1 <= '0;
    end else if (i_en) begin
      r_c1.vld  <= i_vld;
      r_c1.sat  <= w_sat;
      r_c1.sign <= w_xc[W-1];
`ifdef SIGMOID_TANH_EN
      r_c1.mode <= i_mode;
`endif
    end
  end

  // S1 data: t is only loaded for real vectors; bubbles leave it stale
  always_ff @(posedge clk) begin
    if (i_en && i_vld) r_t <= w_t;
  end

  // S2 control: follows S1 on every advance, bubbles included
  always_ff @(posedge clk) begin
    if (rst)       r_c2 <= '0;
    else if (i_en) r_c2 <= r_c1;
  end

  // S2 data: full 2W-bit square of t, no truncation here
  always_ff @(posedge clk) begin
    if (i_en && r_c1.vld) r_prod <= (2*W)'(r_t) * (2*W)'(r_t);
  end

  // S3 output register: truncated to W bits only at this point
  always_ff @(posedge clk) begin
    if (rst) begin
      o_y   <= '0;
      o_sat <= 1'b0;
    end else if (i_en && r_c2.vld) begin
      o_y   <= W'(w_y);
      o_sat <= r_c2.sat;
    end
  end

endmodule

// File: rtl/sigmoid_pipe.sv
// sigmoid_pipe: LANES-wide sigmoid (or tanh when SIGMOID_TANH_EN is defined) sharing one valid/ready pair.
// Latency: 3 cycles input transfer to out_valid, 1 vector per cycle.
// Backpressure: whole pipe stalls when out_valid && !out_ready; in_ready mirrors the advance enable.
module sigmoid_pipe
  import sigmoid_pkg::*;
#(
  parameter int W     = 16,
  parameter int F     = W / 2,
  parameter int LANES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LANES*W-1:0] in_data,
`ifdef SIGMOID_TANH_EN
  input  logic               in_mode,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*W-1:0] out_data,
  output logic [LANES-1:0]   out_sat
);

  logic       w_en;
  logic [2:0] r_vld;

  // Advance whenever the output slot is empty or being drained
  assign w_en      = !r_vld[2] || out_ready;
  assign in_ready  = w_en;
  assign out_valid = r_vld[2];

  // Stage valid bits shift together; a low in_valid becomes a bubble that is kept while stalled
  always_ff @(posedge clk) begin
    if (rst)       r_vld <= '0;
    else if (w_en) r_vld <= {r_vld[1:0], in_valid};
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    sigmoid_lane #(
      .W (W),
      .F (F)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .i_en   (w_en),
      .i_vld  (in_valid),
`ifdef SIGMOID_TANH_EN
      .i_mode (in_mode),
`endif
      .i_x    (in_data[g*W +: W]),
      .o_y    (out_data[g*W +: W]),
      .o_sat  (out_sat[g])
    );
  end

endmodule

// File: tb/tb_sigmoid_pipe.sv
// tb_sigmoid_pipe: randomized scoreboard bench for sigmoid_pipe (W=16, F=8, LANES=4).
// Expected results come from an integer model of the sigmoid/tanh rules, queued in acceptance order.
// Directed vectors, hold-while-stalled, reset flush and a long random stream with random out_ready.
module tb_sigmoid_pipe;

  localparam int W     = 16;
  localparam int F     = 8;
  localparam int LANES = 4;
  localparam int ONE   = 1 << F;
  localparam int SATV  = 4 << F;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [LANES*W-1:0] in_data;
  logic               out_valid;
  logic               out_ready;
  logic [LANES*W-1:0] out_data;
  logic [LANES-1:0]   out_sat;
  bit                 mode_b;
`ifdef SIGMOID_TANH_EN
  logic               in_mode;
  assign in_mode = mode_b;
`endif

  always #5 clk = ~clk;

  sigmoid_pipe #(
    .W     (W),
    .F     (F),
    .LANES (LANES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
`ifdef SIGMOID_TANH_EN
    .in_mode   (in_mode),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat)
  );

  typedef struct {
    logic [LANES*W-1:0] dat;
    logic [LANES-1:0]   sat;
    int                 cyc;
  } exp_t;

  exp_t               q[$];
  int                 n_chk = 0;
  int                 n_err = 0;
  int                 cyc   = 0;
  int                 n_acc = 0;
  bit                 lat_on;
  bit                 held;
  logic [LANES*W-1:0] hold_dat;
  logic [LANES-1:0]   hold_sat;
  logic [LANES*W-1:0] last_dat;
  logic [LANES-1:0]   last_sat;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Sigmoid approximation straight from its definition, in plain integers
  function automatic int ref_sig(input int x, output bit sat);
    int a, t, s;
    sat = 1'b0;
    if (x >= SATV) begin sat = 1'b1; return ONE; end
    if (x <= -SATV) begin sat = 1'b1; return 0; end
    a = ((x < 0) ? -x : x) / 4;
    t = ONE - a;
    s = (t * t) / (2 * ONE);
    return (x < 0) ? s : ONE - s;
  endfunction

  function automatic exp_t make_exp(input logic [LANES*W-1:0] d, input bit m);
    exp_t e;
    int   x, y;
    bit   s;
    e.dat = '0;
    e.sat = '0;
    e.cyc = 0;
    for (int i = 0; i < LANES; i++) begin
      x = int'($signed(d[i*W +: W]));
      if (m) begin
        x = 2 * x;
        if (x > SATV)  x = SATV;
        if (x < -SATV) x = -SATV;
        y = 2 * ref_sig(x, s) - ONE;
      end else begin
        y = ref_sig(x, s);
      end
      e.dat[i*W +: W] = y[W-1:0];
      e.sat[i]        = s;
    end
    return e;
  endfunction

  function automatic logic [W-1:0] rand_x();
    int v;
    case ($urandom_range(0, 4))
      0:       v = int'($urandom);
      1:       v = ($urandom_range(0, 1) != 0) ? 32'h0000_7FFF : 32'hFFFF_8000;
      default: v = int'($urandom_range(0, 2 * SATV + 20)) - SATV - 10;
    endcase
    return v[W-1:0];
  endfunction

  function automatic logic [LANES*W-1:0] rand_vec();
    logic [LANES*W-1:0] d;
    for (int i = 0; i < LANES; i++) d[i*W +: W] = rand_x();
    return d;
  endfunction

  // One clock: observe at the falling edge, then return just after the rising edge
  task automatic step();
    exp_t e;
    @(negedge clk);
    if (held) begin
      chk("hold_vld", out_valid, 1);
      chk("hold_dat", out_data, hold_dat);
      chk("hold_sat", out_sat, hold_sat);
    end
    if (rst) begin
      q.delete();
      held = 1'b0;
    end else begin
      if (out_valid && !out_ready) chk("stall_rdy", in_ready, 0);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("spurious", out_valid, 0);
        end else begin
          e = q.pop_front();
          chk("dat", out_data, e.dat);
          chk("sat", out_sat, e.sat);
          if (lat_on) chk("latency", cyc - e.cyc, 3);
          last_dat = out_data;
          last_sat = out_sat;
        end
      end
      if (in_valid && in_ready) begin
        e     = make_exp(in_data, mode_b);
        e.cyc = cyc;
        q.push_back(e);
        n_acc++;
      end
      held     = out_valid && !out_ready;
      hold_dat = out_data;
      hold_sat = out_sat;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic directed(input string tag, input logic [LANES*W-1:0] x,
                          input logic [LANES*W-1:0] y, input logic [LANES-1:0] s);
    last_dat  = '1;
    last_sat  = '0;
    in_valid  = 1'b1;
    in_data   = x;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (3) step();
    chk({tag, "_dat"}, last_dat, y);
    chk({tag, "_sat"}, last_sat, s);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached with %0d vectors queued", q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    mode_b    = 1'b0;
    lat_on    = 1'b1;
    held      = 1'b0;
    last_dat  = '0;
    last_sat  = '0;
    hold_dat  = '0;
    hold_sat  = '0;
    step();
    step();
    rst = 1'b0;
    chk("rst_ovld", out_valid, 0);
    chk("rst_dat", out_data, 0);
    chk("rst_sat", out_sat, 0);
    chk("rst_rdy", in_ready, 1);

    directed("mid", 64'h0400_FE00_0200_0000, 64'h0100_0020_00E0_0080, 4'b1000);
    directed("edge", 64'hFC01_7FFF_FC00_8000, 64'h0000_0100_0000_0000, 4'b0111);

    // Back-to-back pair with no gaps, then idle until drained
    in_valid = 1'b1;
    in_data  = 64'h0001_FFFF_03FF_FC02;
    step();
    in_data  = 64'h0100_FF00_0080_FF80;
    step();
    in_valid = 1'b0;
    repeat (4) step();

    // Reset with two vectors in flight: both must vanish
    in_valid = 1'b1;
    in_data  = rand_vec();
    step();
    in_data  = rand_vec();
    step();
    in_valid = 1'b0;
    rst      = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_vld", out_valid, 0);
    chk("mid_rst_rdy", in_ready, 1);
    repeat (6) step();

`ifdef SIGMOID_TANH_EN
    mode_b = 1'b1;
    directed("tanh", 64'h0300_0000_0300_0000, 64'h0100_0000_0100_0000, 4'b1010);
    mode_b = 1'b0;
`endif

    // Short stream of 10 vectors under heavy backpressure
    lat_on = 1'b0;
    n_acc  = 0;
    for (int i = 0; i < 200 && n_acc < 10; i++) begin
      in_valid  = 1'b1;
      in_data   = rand_vec();
      out_ready = ($urandom_range(0, 1) != 0);
      step();
    end
    chk("stream10_acc", n_acc, 10);

    // Long random stream: random valid, random ready, random operands
    n_acc = 0;
    for (int i = 0; i < 20000 && n_acc < 2600; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = rand_vec();
      out_ready = ($urandom_range(0, 2) != 0);
`ifdef SIGMOID_TANH_EN
      mode_b    = ($urandom_range(0, 1) != 0);
`endif
      step();
    end
    chk("random_acc", n_acc, 2600);

    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && q.size() > 0; i++) step();
    chk("drain", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
